// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard scheduler: FSM encodings,
// the zero-register constant, default mul/div latencies and a register
// match helper.
package hazard_pkg;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_t;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_t;

  localparam logic [4:0] REG_ZERO    = 5'd0;
  localparam int         MUL_LAT_DEF = 4;
  localparam int         DIV_LAT_DEF = 32;

  // A source register depends on a producer only when the numbers agree
  // and the producer is not writing $zero (writes to $zero are discarded).
  function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
    return (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter with a busy flag. A start in idle loads the
// counter and raises busy on the next edge; busy then lasts load_val+1
// cycles. Starts while busy are ignored.
module md_timer
  import hazard_pkg::*;
#(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load_val,
  output logic         busy
);

  md_state_t      state_r;
  md_state_t      state_nx_s;
  logic [W-1:0]   cnt_r;
  logic [W-1:0]   cnt_nx_s;

  // State and counter registers; reset abandons any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= MD_IDLE;
      cnt_r   <= {W{1'b0}};
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
    end
  end

  // Next state: load on start from idle, count down while busy, leave at zero.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      MD_IDLE: begin
        if (start) begin
          state_nx_s = MD_BUSY;
          cnt_nx_s   = load_val;
        end else begin
          state_nx_s = MD_IDLE;
          cnt_nx_s   = cnt_r;
        end
      end
      MD_BUSY: begin
        if (cnt_r == {W{1'b0}}) begin
          state_nx_s = MD_IDLE;
          cnt_nx_s   = {W{1'b0}};
        end else begin
          state_nx_s = MD_BUSY;
          cnt_nx_s   = cnt_r - {{(W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_nx_s = MD_IDLE;
        cnt_nx_s   = {W{1'b0}};
      end
    endcase
  end

  assign busy = (state_r == MD_BUSY);

endmodule

// File: rtl/hazard_sched.sv
// Pipeline hazard scheduler for the 5-stage MIPS core. Produces the
// per-stage stall/flush enables for hazards forwarding cannot cover
// (load-use, decode branch operands, mul/div busy window, data-memory
// wait states) and counts stall cycles with saturation.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic             usesrsD,
  input  logic             usesrtD,
  input  logic             branchD,
  input  logic             mdopD,
  input  logic [4:0]       writeregE,
  input  logic             regwriteE,
  input  logic             memtoregE,
  input  logic [4:0]       writeregM,
  input  logic             memtoregM,
  input  logic             mdstartE,
  input  logic             mdisdivE,
  input  logic             dmemreqM,
  input  logic             dmemackM,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             flushE,
  output logic             flushW,
  output logic             mdbusy,
  output logic [CNT_W-1:0] stallcnt
);

  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MD_W    = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam logic [MD_W-1:0] MUL_LOAD = MD_W'(MUL_LAT - 1);
  localparam logic [MD_W-1:0] DIV_LOAD = MD_W'(DIV_LAT - 1);

  logic             lwstall_s;
  logic             brstall_s;
  logic             mdstall_s;
  logic             memwait_s;
  logic             md_busy_s;
  logic [MD_W-1:0]  md_load_s;
  mem_state_t       mem_state_r;
  mem_state_t       mem_state_nx_s;
  logic [CNT_W-1:0] stallcnt_r;
  logic             stall_f_s;
  logic             stall_d_s;
  logic             stall_e_s;
  logic             stall_m_s;
  logic             flush_e_s;
  logic             flush_w_s;

  // Hazard detection terms.
  assign lwstall_s = memtoregE & regwriteE &
                     ((usesrsD & reg_match(rsD, writeregE)) |
                      (usesrtD & reg_match(rtD, writeregE)));
  assign brstall_s = branchD &
                     ((regwriteE & (reg_match(rsD, writeregE) | reg_match(rtD, writeregE))) |
                      (memtoregM & (reg_match(rsD, writeregM) | reg_match(rtD, writeregM))));
  assign mdstall_s = md_busy_s & mdopD;
  assign memwait_s = dmemreqM & ~dmemackM;
  assign md_load_s = mdisdivE ? DIV_LOAD : MUL_LOAD;

  md_timer #(
    .W (MD_W)
  ) u_md (
    .clk      (clk),
    .reset    (reset),
    .start    (mdstartE),
    .load_val (md_load_s),
    .busy     (md_busy_s)
  );

  assign mdbusy = md_busy_s;

  // Memory handshake state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_state_r <= MEM_IDLE;
    end else begin
      mem_state_r <= mem_state_nx_s;
    end
  end

  // Memory handshake next state; a dropped request without ack returns to idle.
  always_comb begin
    mem_state_nx_s = mem_state_r;
    case (mem_state_r)
      MEM_IDLE: begin
        if (memwait_s) begin
          mem_state_nx_s = MEM_WAIT;
        end else begin
          mem_state_nx_s = MEM_IDLE;
        end
      end
      MEM_WAIT: begin
        if (dmemackM || !dmemreqM) begin
          mem_state_nx_s = MEM_IDLE;
        end else begin
          mem_state_nx_s = MEM_WAIT;
        end
      end
      default: begin
        mem_state_nx_s = MEM_IDLE;
      end
    endcase
  end

  // Output priority: memory wait freezes the whole pipe, decode hazards
  // insert a bubble into E, reset forces everything off.
  always_comb begin
    stall_f_s = 1'b0;
    stall_d_s = 1'b0;
    stall_e_s = 1'b0;
    stall_m_s = 1'b0;
    flush_e_s = 1'b0;
    flush_w_s = 1'b0;
    if (reset) begin
      stall_f_s = 1'b0;
    end else if (memwait_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      stall_e_s = 1'b1;
      stall_m_s = 1'b1;
      flush_w_s = 1'b1;
    end else if (lwstall_s || brstall_s || mdstall_s) begin
      stall_f_s = 1'b1;
      stall_d_s = 1'b1;
      flush_e_s = 1'b1;
    end else begin
      stall_f_s = 1'b0;
    end
  end

  assign stallF = stall_f_s;
  assign stallD = stall_d_s;
  assign stallE = stall_e_s;
  assign stallM = stall_m_s;
  assign flushE = flush_e_s;
  assign flushW = flush_w_s;

  // Saturating count of cycles in which fetch was held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallcnt_r <= {CNT_W{1'b0}};
    end else if (stall_f_s && (stallcnt_r != {CNT_W{1'b1}})) begin
      stallcnt_r <= stallcnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stallcnt_r <= stallcnt_r;
    end
  end

  assign stallcnt = stallcnt_r;

endmodule
